// File: rtl/plic_ng.sv
// -----------------------------------------------------------------------------
// plic_ng - second-generation platform interrupt controller.
//
// Arbitrates NUM_SRC external interrupt lines by programmable priority against
// a threshold. Edge-type sources are latched as pending; level-type sources
// follow their line. Exactly one interrupt may be in service at a time: once a
// delivery is accepted no further delivery happens until mret retires. The
// block can optionally wait for a WFI before delivering. It can also
// optionally treat source 0 as a notify event that restricts delivery to a
// single target source.
//
// Ports
//   clk           single clock
//   rst           asynchronous, active-low reset
//   interrupt_i   raw interrupt lines, one per source
//   cfg_en_i      per-source enable
//   cfg_prio_i    packed priorities, source i at [i*PRIO_BITS +: PRIO_BITS]
//   cfg_thresh_i  delivery threshold (priority must be strictly greater)
//   ifid_en_i     pipeline accepts the trap (acknowledge while delivering)
//   csr_wfi_i     WFI in execution
//   csr_mret_i    mret retiring (only meaningful while in service)
//   csr_retpc_i   return PC presented by the CSR unit
//   int_taken_o   trap request, high for the whole delivery
//   int_id_o      delivered source index + 1, held through service, else 0
//   mretpc_o      return PC captured when the delivery was accepted
//   pend_o        registered pending vector for status
// -----------------------------------------------------------------------------
module plic_ng #(
    parameter int                 NUM_SRC   = 4,
    parameter int                 PRIO_BITS = 2,
    parameter int                 ID_BITS   = 3,
    parameter int                 ADDR_BITS = 32,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = 4'b0011,
    parameter bit                 WFI_ONLY  = 1'b1,
    parameter bit                 LOCK_EN   = 1'b1,
    parameter int                 LOCK_TGT  = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC-1:0]             interrupt_i,
    input  logic [NUM_SRC-1:0]             cfg_en_i,
    input  logic [NUM_SRC*PRIO_BITS-1:0]   cfg_prio_i,
    input  logic [PRIO_BITS-1:0]           cfg_thresh_i,
    input  logic                           ifid_en_i,
    input  logic                           csr_wfi_i,
    input  logic                           csr_mret_i,
    input  logic [ADDR_BITS-1:0]           csr_retpc_i,
    output logic                           int_taken_o,
    output logic [ID_BITS-1:0]             int_id_o,
    output logic [ADDR_BITS-1:0]           mretpc_o,
    output logic [NUM_SRC-1:0]             pend_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_DELIVER = 2'd2,
        ST_SERVICE = 2'd3
    } state_t;

    // Interrupt ID of a source index (index + 1, 0 is reserved for "none").
    function automatic logic [ID_BITS-1:0] src_id(input int idx);
        return ID_BITS'(idx + 1);
    endfunction

    state_t                 state_r;
    state_t                 state_s;
    logic [NUM_SRC-1:0]     irq_prev_r;
    logic                   prime_r;
    logic [NUM_SRC-1:0]     edge_s;
    logic [NUM_SRC-1:0]     clr_s;
    logic [NUM_SRC-1:0]     pend_edge_r;
    logic [NUM_SRC-1:0]     pend_edge_s;
    logic [NUM_SRC-1:0]     pend_s;
    logic [NUM_SRC-1:0]     pend_o_r;
    logic [NUM_SRC-1:0]     elig_s;
    logic [PRIO_BITS-1:0]   prio_s [NUM_SRC];
    logic                   lock_r;
    logic                   lock_s;
    logic                   win_vld_s;
    logic [PRIO_BITS-1:0]   win_prio_s;
    logic [ID_BITS-1:0]     win_id_s;
    logic [ID_BITS-1:0]     id_r;
    logic [ID_BITS-1:0]     id_s;
    logic                   accept_s;
    logic                   taken_r;
    logic [ADDR_BITS-1:0]   mretpc_r;

    assign accept_s = (state_r == ST_DELIVER) && ifid_en_i;

    // Edge detection, pending set/clear and the status view of pending.
    always_comb begin
        // prime_r is low for the first cycle after reset so that a line that
        // was already high before reset is not mistaken for a fresh edge.
        edge_s = interrupt_i & ~irq_prev_r & {NUM_SRC{prime_r}};
        for (int i = 0; i < NUM_SRC; i++) begin
            clr_s[i] = accept_s && (id_r == src_id(i));
        end
        // A new edge in the same cycle as the clear keeps the bit pending.
        pend_edge_s = ((pend_edge_r & ~clr_s) | edge_s) & EDGE_MASK;
        pend_s      = (pend_edge_r & EDGE_MASK) | (interrupt_i & ~EDGE_MASK);
    end

    // Lock state: set by a source-0 edge, released when the target is accepted.
    always_comb begin
        if (!LOCK_EN) begin
            lock_s = 1'b0;
        end else if (accept_s && (id_r == src_id(LOCK_TGT))) begin
            lock_s = 1'b0;
        end else if (edge_s[0]) begin
            lock_s = 1'b1;
        end else begin
            lock_s = lock_r;
        end
    end

    // Per-source eligibility: pending, enabled, above threshold, lock filter.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            prio_s[i] = cfg_prio_i[i*PRIO_BITS +: PRIO_BITS];
            if (LOCK_EN && (i == 0)) begin
                elig_s[i] = 1'b0;
            end else if (LOCK_EN && lock_r && (i != LOCK_TGT)) begin
                elig_s[i] = 1'b0;
            end else begin
                elig_s[i] = pend_s[i] && cfg_en_i[i] && (prio_s[i] > cfg_thresh_i);
            end
        end
    end

    // Highest-priority eligible source; strict compare keeps the lowest index on ties.
    always_comb begin
        win_vld_s  = 1'b0;
        win_prio_s = '0;
        win_id_s   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig_s[i] && (!win_vld_s || (prio_s[i] > win_prio_s))) begin
                win_vld_s  = 1'b1;
                win_prio_s = prio_s[i];
                win_id_s   = src_id(i);
            end else begin
                win_vld_s  = win_vld_s;
            end
        end
    end

    // Delivery FSM next state; the winner is latched only on entry to DELIVER.
    always_comb begin
        state_s = state_r;
        id_s    = id_r;
        case (state_r)
            ST_IDLE: begin
                if (WFI_ONLY) begin
                    if (csr_wfi_i) begin
                        state_s = ST_ARMED;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (win_vld_s) begin
                    state_s = ST_DELIVER;
                    id_s    = win_id_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (win_vld_s && !csr_wfi_i) begin
                    state_s = ST_DELIVER;
                    id_s    = win_id_s;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_DELIVER: begin
                if (ifid_en_i) begin
                    state_s = ST_SERVICE;
                end else begin
                    state_s = ST_DELIVER;
                end
            end
            ST_SERVICE: begin
                if (csr_mret_i) begin
                    state_s = ST_IDLE;
                    id_s    = '0;
                end else begin
                    state_s = ST_SERVICE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                id_s    = '0;
            end
        endcase
    end

    // Line history, pending latches and lock register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_prev_r  <= '0;
            prime_r     <= 1'b0;
            pend_edge_r <= '0;
            lock_r      <= 1'b0;
        end else begin
            irq_prev_r  <= interrupt_i;
            prime_r     <= 1'b1;
            pend_edge_r <= pend_edge_s;
            lock_r      <= lock_s;
        end
    end

    // FSM state and latched delivery ID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            id_r    <= '0;
        end else begin
            state_r <= state_s;
            id_r    <= id_s;
        end
    end

    // Registered outputs: trap request, saved return PC, pending status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taken_r  <= 1'b0;
            mretpc_r <= '0;
            pend_o_r <= '0;
        end else begin
            taken_r  <= (state_s == ST_DELIVER);
            if (accept_s) begin
                mretpc_r <= csr_retpc_i;
            end else begin
                mretpc_r <= mretpc_r;
            end
            pend_o_r <= pend_edge_s | (interrupt_i & ~EDGE_MASK);
        end
    end

    assign int_taken_o = taken_r;
    assign int_id_o    = id_r;
    assign mretpc_o    = mretpc_r;
    assign pend_o      = pend_o_r;

endmodule

// File: tb/tb_plic_ng.sv
// -----------------------------------------------------------------------------
// tb_plic_ng - scoreboard bench for plic_ng.
//
// Two instances: dut_a (no WFI gating, no lock, sources 0-2 edge, 3 level)
// and dut_b (default parameters: WFI gating, lock on source 0, target 1).
// Stimulus pushes the expected ID and the cycle in which int_taken_o must rise.
// One monitor per instance pops and compares on every rising int_taken_o.
// -----------------------------------------------------------------------------
module tb_plic_ng;

    typedef struct {
        logic [2:0] id;
        int         cyc;
    } exp_t;

    logic clk;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    logic a_prev = 1'b0;
    logic b_prev = 1'b0;

    // dut_a signals
    logic        a_rst;
    logic [3:0]  a_irq, a_en, a_pend;
    logic [7:0]  a_prio;
    logic [1:0]  a_thr;
    logic        a_ifid, a_wfi, a_mret, a_taken;
    logic [31:0] a_retpc, a_mretpc;
    logic [2:0]  a_id;

    // dut_b signals
    logic        b_rst;
    logic [3:0]  b_irq, b_en, b_pend;
    logic [7:0]  b_prio;
    logic [1:0]  b_thr;
    logic        b_ifid, b_wfi, b_mret, b_taken;
    logic [31:0] b_retpc, b_mretpc;
    logic [2:0]  b_id;

    int t, c, r, s, m, w;

    plic_ng #(
        .NUM_SRC(4), .PRIO_BITS(2), .ID_BITS(3), .ADDR_BITS(32),
        .EDGE_MASK(4'b0111), .WFI_ONLY(1'b0), .LOCK_EN(1'b0), .LOCK_TGT(1)
    ) dut_a (
        .clk(clk), .rst(a_rst), .interrupt_i(a_irq), .cfg_en_i(a_en),
        .cfg_prio_i(a_prio), .cfg_thresh_i(a_thr), .ifid_en_i(a_ifid),
        .csr_wfi_i(a_wfi), .csr_mret_i(a_mret), .csr_retpc_i(a_retpc),
        .int_taken_o(a_taken), .int_id_o(a_id), .mretpc_o(a_mretpc), .pend_o(a_pend)
    );

    plic_ng dut_b (
        .clk(clk), .rst(b_rst), .interrupt_i(b_irq), .cfg_en_i(b_en),
        .cfg_prio_i(b_prio), .cfg_thresh_i(b_thr), .ifid_en_i(b_ifid),
        .csr_wfi_i(b_wfi), .csr_mret_i(b_mret), .csr_retpc_i(b_retpc),
        .int_taken_o(b_taken), .int_id_o(b_id), .mretpc_o(b_mretpc), .pend_o(b_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for dut_a: every rising trap request must match the scoreboard head.
    always @(negedge clk) begin
        if (a_taken && !a_prev) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_delivery: actual id=%0d required no delivery (cycle %0d)", a_id, cyc);
            end else begin
                ea = qa.pop_front();
                check("a_sb_id", 32'(a_id), 32'(ea.id));
                check("a_sb_cycle", 32'(cyc), 32'(ea.cyc));
            end
        end
        a_prev = a_taken;
    end

    // Monitor for dut_b.
    always @(negedge clk) begin
        if (b_taken && !b_prev) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_delivery: actual id=%0d required no delivery (cycle %0d)", b_id, cyc);
            end else begin
                eb = qb.pop_front();
                check("b_sb_id", 32'(b_id), 32'(eb.id));
                check("b_sb_cycle", 32'(cyc), 32'(eb.cyc));
            end
        end
        b_prev = b_taken;
    end

    initial begin
        a_rst = 1'b0; a_irq = 4'b0; a_en = 4'b1111; a_prio = {2'd3, 2'd2, 2'd2, 2'd2};
        a_thr = 2'd0; a_ifid = 1'b0; a_wfi = 1'b0; a_mret = 1'b0; a_retpc = 32'd0;
        b_rst = 1'b0; b_irq = 4'b0; b_en = 4'b1111; b_prio = {2'd3, 2'd1, 2'd2, 2'd3};
        b_thr = 2'd0; b_ifid = 1'b0; b_wfi = 1'b0; b_mret = 1'b0; b_retpc = 32'd0;

        // Reset values
        #2;
        check("a_rst_taken", 32'(a_taken), 32'd0);
        check("a_rst_id", 32'(a_id), 32'd0);
        check("a_rst_mretpc", a_mretpc, 32'd0);
        check("a_rst_pend", 32'(a_pend), 32'd0);
        check("b_rst_taken", 32'(b_taken), 32'd0);
        check("b_rst_id", 32'(b_id), 32'd0);
        tick();
        tick();
        a_rst = 1'b1;
        b_rst = 1'b1;
        tick();
        tick();

        // ---------------- dut_a: priority arbitration, tie to lowest index
        a_irq = 4'b0110;
        t = cyc;
        qa.push_back('{id: 3'd2, cyc: t + 2});
        tick();
        check("a_pend_edge", 32'(a_pend), 32'h6);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("a_hold_taken", 32'(a_taken), 32'd1);
            tick();
        end
        a_ifid = 1'b1;
        a_retpc = 32'h0000_1234;
        check("a_taken_ack_cycle", 32'(a_taken), 32'd1);
        tick();
        a_ifid = 1'b0;
        a_retpc = 32'h0000_DEAD;
        check("a_taken_after_ack", 32'(a_taken), 32'd0);
        check("a_mretpc_saved", a_mretpc, 32'h0000_1234);
        check("a_id_service", 32'(a_id), 32'd2);
        check("a_pend_after_clear", 32'(a_pend), 32'h4);
        tick();
        check("a_mretpc_stable", a_mretpc, 32'h0000_1234);
        a_mret = 1'b1;
        c = cyc;
        qa.push_back('{id: 3'd3, cyc: c + 2});
        tick();
        a_mret = 1'b0;
        check("a_id_idle_after_mret", 32'(a_id), 32'd0);
        check("a_taken_idle_after_mret", 32'(a_taken), 32'd0);
        tick();
        check("a_second_id", 32'(a_id), 32'd3);
        a_ifid = 1'b1;
        tick();
        a_ifid = 1'b0;
        check("a_pend_all_clear", 32'(a_pend), 32'h0);
        a_mret = 1'b1;
        tick();
        a_mret = 1'b0;
        a_irq = 4'b0;
        tick();

        // mret while idle has no effect
        a_mret = 1'b1;
        tick();
        a_mret = 1'b0;
        tick();
        check("a_mret_idle_taken", 32'(a_taken), 32'd0);
        check("a_mret_idle_id", 32'(a_id), 32'd0);
        check("a_mret_idle_mretpc", a_mretpc, 32'h0000_DEAD);

        // ---------------- dut_a: threshold and lost winner
        a_thr = 2'd2;
        a_prio = {2'd2, 2'd2, 2'd2, 2'd2};
        a_irq = 4'b1000;
        tick();
        tick();
        tick();
        check("a_thresh_pend", 32'(a_pend), 32'h8);
        check("a_thresh_blocked", 32'(a_taken), 32'd0);
        a_prio = {2'd3, 2'd2, 2'd2, 2'd2};
        r = cyc;
        qa.push_back('{id: 3'd4, cyc: r + 1});
        tick();
        check("a_thresh_id", 32'(a_id), 32'd4);
        a_irq = 4'b0000;
        tick();
        check("a_lost_winner_taken", 32'(a_taken), 32'd1);
        check("a_lost_winner_id", 32'(a_id), 32'd4);
        a_ifid = 1'b1;
        tick();
        a_ifid = 1'b0;
        a_mret = 1'b1;
        tick();
        a_mret = 1'b0;
        a_thr = 2'd0;
        tick();

        // ---------------- dut_a: asynchronous reset during DELIVER
        a_irq = 4'b0010;
        t = cyc;
        qa.push_back('{id: 3'd2, cyc: t + 2});
        tick();
        tick();
        @(negedge clk);
        #1;
        a_rst = 1'b0;
        #1;
        check("a_async_rst_taken", 32'(a_taken), 32'd0);
        check("a_async_rst_id", 32'(a_id), 32'd0);
        check("a_async_rst_mretpc", a_mretpc, 32'd0);
        check("a_async_rst_pend", 32'(a_pend), 32'd0);
        tick();
        a_rst = 1'b1;
        repeat (5) tick();
        check("a_post_rst_pend", 32'(a_pend), 32'd0);
        check("a_post_rst_taken", 32'(a_taken), 32'd0);
        a_irq = 4'b0000;
        tick();
        a_irq = 4'b0010;
        t = cyc;
        qa.push_back('{id: 3'd2, cyc: t + 2});
        tick();
        tick();
        check("a_post_rst_id", 32'(a_id), 32'd2);
        a_ifid = 1'b1;
        tick();
        a_ifid = 1'b0;
        a_mret = 1'b1;
        tick();
        a_mret = 1'b0;
        a_irq = 4'b0000;
        tick();

        // ---------------- dut_b: WFI gating
        b_irq = 4'b0010;
        repeat (4) tick();
        check("b_wfi_pend", 32'(b_pend), 32'h2);
        check("b_wfi_blocked", 32'(b_taken), 32'd0);
        b_wfi = 1'b1;
        w = cyc;
        qb.push_back('{id: 3'd2, cyc: w + 2});
        tick();
        b_wfi = 1'b0;
        check("b_armed_id", 32'(b_id), 32'd0);
        check("b_armed_taken", 32'(b_taken), 32'd0);
        tick();
        check("b_wfi_taken", 32'(b_taken), 32'd1);
        b_ifid = 1'b1;
        b_retpc = 32'h0000_0100;
        tick();
        b_ifid = 1'b0;
        b_irq = 4'b0000;
        check("b_mretpc", b_mretpc, 32'h0000_0100);
        check("b_pend_clear", 32'(b_pend), 32'h0);
        b_mret = 1'b1;
        tick();
        b_mret = 1'b0;
        tick();

        // ---------------- dut_b: lock on source 0, target source 1
        b_irq = 4'b0001;
        tick();
        b_irq = 4'b1001;
        b_wfi = 1'b1;
        tick();
        b_wfi = 1'b0;
        repeat (4) tick();
        check("b_lock_blocked", 32'(b_taken), 32'd0);
        check("b_lock_pend", 32'(b_pend), 32'h9);
        b_irq = 4'b1011;
        s = cyc;
        qb.push_back('{id: 3'd2, cyc: s + 2});
        tick();
        tick();
        check("b_lock_tgt_id", 32'(b_id), 32'd2);
        b_ifid = 1'b1;
        tick();
        b_ifid = 1'b0;
        b_mret = 1'b1;
        m = cyc;
        tick();
        b_mret = 1'b0;
        b_wfi = 1'b1;
        qb.push_back('{id: 3'd4, cyc: m + 3});
        tick();
        b_wfi = 1'b0;
        tick();
        check("b_unlocked_id", 32'(b_id), 32'd4);
        b_ifid = 1'b1;
        b_irq = 4'b0011;
        tick();
        b_ifid = 1'b0;
        b_mret = 1'b1;
        tick();
        b_mret = 1'b0;
        tick();
        check("b_final_pend", 32'(b_pend), 32'h1);

        repeat (3) tick();
        check("a_queue_drained", 32'(qa.size()), 32'd0);
        check("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
